// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Defaults assume a 50 MHz core clock.
  localparam int unsigned DefSyncStages      = 2;
  localparam int unsigned DefDebounceCycles  = 500000;    // 10 ms
  localparam int unsigned DefLongPressCycles = 50000000;  // 1 s

  // Counter width able to hold max_val; never narrower than one bit so a
  // disabled timer (max_val = 0) still has a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input.
module sync_ff #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [Stages-1:0] ff;

  // Shift the pin through the chain; reset parks every stage at the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {Stages{ResetVal}};
    end else begin
      ff <= {ff[Stages-2:0], din};
    end
  end

  assign dout = ff[Stages-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit press/release/long-press pulses.
//
// state        | meaning
// -------------+--------------------------------------------------------
// RELEASED     | button idle, waiting for a pressed sample
// WAIT_PRESS   | pressed level seen, counting stable cycles before accept
// PRESSED      | press accepted, long-press timer running
// WAIT_RELEASE | released level seen, counting stable cycles before accept
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned SyncStages      = DefSyncStages,
  parameter int unsigned DebounceCycles  = DefDebounceCycles,
  parameter int unsigned LongPressCycles = DefLongPressCycles,
  parameter bit          ActiveLow       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam int unsigned DebW        = cnt_width(DebounceCycles);
  localparam int unsigned HoldW       = cnt_width(LongPressCycles);
  localparam bit          LongEn      = (LongPressCycles != 0);
  localparam int unsigned HoldLastInt = LongEn ? (LongPressCycles - 1) : 0;

  localparam logic [DebW-1:0]  DebLast  = DebW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldLastInt);
  localparam logic [HoldW-1:0] HoldMax  = {HoldW{1'b1}};

  logic             btn_sync;
  logic             btn_s;
  state_t           state, state_nxt;
  logic [DebW-1:0]  deb_cnt;
  logic [HoldW-1:0] hold_cnt;
  logic             deb_inc;
  logic             long_done;
  logic             in_hold;
  logic             pressed_nxt;
  logic             long_hit;

  sync_ff #(
    .Stages   (SyncStages),
    .ResetVal (ActiveLow)
  ) u_sync_btn (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (btn_i),
    .dout (btn_sync)
  );

  assign btn_s = btn_sync ^ ActiveLow;

  // Next-state decode; the debounce counter only advances while a candidate level holds.
  always_comb begin
    state_nxt = state;
    deb_inc   = 1'b0;
    case (state)
      RELEASED: begin
        if (btn_s) state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!btn_s)                 state_nxt = RELEASED;
        else if (deb_cnt == DebLast) state_nxt = PRESSED;
        else                        deb_inc   = 1'b1;
      end
      PRESSED: begin
        if (!btn_s) state_nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (btn_s)                  state_nxt = PRESSED;
        else if (deb_cnt == DebLast) state_nxt = RELEASED;
        else                        deb_inc   = 1'b1;
      end
      default: state_nxt = RELEASED;
    endcase
  end

  assign in_hold     = (state == PRESSED) || (state == WAIT_RELEASE);
  assign pressed_nxt = (state_nxt == PRESSED) || (state_nxt == WAIT_RELEASE);

  // Release acceptance wins over a long-press threshold on the same cycle.
  assign long_hit = LongEn && in_hold && pressed_nxt && !long_done &&
                    (hold_cnt == HoldLast);

  // State and timers; the hold timer survives release bounces so long-press timing is not restarted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RELEASED;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      deb_cnt <= deb_inc ? deb_cnt + 1'b1 : '0;
      if (state_nxt == RELEASED) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else begin
        if (in_hold && hold_cnt != HoldMax) hold_cnt <= hold_cnt + 1'b1;
        if (long_hit)                       long_done <= 1'b1;
      end
    end
  end

  // Registered outputs derived from the transition being taken this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pressed_o    <= 1'b0;
      press_o      <= 1'b0;
      release_o    <= 1'b0;
      long_press_o <= 1'b0;
    end else begin
      pressed_o    <= pressed_nxt;
      press_o      <= pressed_nxt && !in_hold;
      release_o    <= !pressed_nxt && in_hold;
      long_press_o <= long_hit;
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with short timing (4-cycle debounce, 20-cycle long press).
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic pressed;
  logic press;
  logic rel;
  logic long_p;

  int checks = 0;
  int errors = 0;

  // Per-window event log; cyc is the edge index inside the current window.
  int cyc;
  int press_cnt, press_at;
  int rel_cnt, rel_at;
  int long_cnt, long_at;
  int pressed_cnt, pressed_at;

  button_debounce #(
    .SyncStages      (2),
    .DebounceCycles  (4),
    .LongPressCycles (20),
    .ActiveLow       (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .btn_i        (btn),
    .pressed_o    (pressed),
    .press_o      (press),
    .release_o    (rel),
    .long_press_o (long_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    cyc         = -1;
    press_cnt   = 0; press_at   = -1;
    rel_cnt     = 0; rel_at     = -1;
    long_cnt    = 0; long_at    = -1;
    pressed_cnt = 0; pressed_at = -1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (press === 1'b1) begin press_cnt++; if (press_at < 0) press_at = cyc; end
      if (rel === 1'b1) begin rel_cnt++; if (rel_at < 0) rel_at = cyc; end
      if (long_p === 1'b1) begin long_cnt++; if (long_at < 0) long_at = cyc; end
      if (pressed === 1'b1) begin pressed_cnt++; if (pressed_at < 0) pressed_at = cyc; end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b1;
    clr_log();

    // Reset with button idle
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_outs", int'({pressed, press, rel, long_p}), 0);
    end
    rst = 1'b0;
    clr_log();
    step(3);
    chk("post_rst_outs", int'({pressed, press, rel, long_p}), 0);
    chk("post_rst_events", press_cnt + rel_cnt + long_cnt, 0);

    // Clean press then release
    clr_log();
    btn = 1'b0;
    step(10);
    chk("clean_press_cnt", press_cnt, 1);
    chk("clean_press_at", press_at, 6);
    chk("clean_pressed_at", pressed_at, 6);
    chk("clean_pressed_lvl", int'(pressed), 1);
    chk("clean_other_pulses", rel_cnt + long_cnt, 0);
    clr_log();
    btn = 1'b1;
    step(8);
    chk("clean_rel_cnt", rel_cnt, 1);
    chk("clean_rel_at", rel_at, 6);
    chk("clean_rel_lvl", int'(pressed), 0);
    chk("clean_rel_long", long_cnt, 0);

    // Press bounce shorter than the debounce time
    clr_log();
    for (int i = 0; i < 5; i++) begin
      btn = 1'b0; step(3);
      btn = 1'b1; step(1);
    end
    step(6);
    chk("bounce_press", press_cnt, 0);
    chk("bounce_pressed", pressed_cnt, 0);

    // Long press
    clr_log();
    btn = 1'b0;
    step(40);
    chk("long_press_at", press_at, 6);
    chk("long_cnt", long_cnt, 1);
    chk("long_at", long_at, 26);
    clr_log();
    btn = 1'b1;
    step(8);
    chk("long_rel_at", rel_at, 6);
    chk("long_rel_long", long_cnt, 0);

    // Release glitch while pressed keeps the hold timer running
    clr_log();
    btn = 1'b0;
    step(12);
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    step(20);
    chk("glitch_rel", rel_cnt, 0);
    chk("glitch_pressed_cyc", pressed_cnt, 28);
    chk("glitch_long_at", long_at, 26);
    chk("glitch_long_cnt", long_cnt, 1);
    clr_log();
    btn = 1'b1;
    step(8);
    chk("glitch_rel_at", rel_at, 6);

    // Release accepted on the same cycle the long-press threshold is reached
    clr_log();
    btn = 1'b0;
    step(20);
    btn = 1'b1;
    step(10);
    chk("coll_rel_at", rel_at, 26);
    chk("coll_long_cnt", long_cnt, 0);

    // Reset mid-press with the button still held
    clr_log();
    btn = 1'b0;
    step(10);
    chk("midrst_pressed", int'(pressed), 1);
    rst = 1'b1;
    clr_log();
    step(1);
    chk("midrst_outs", int'({pressed, press, rel, long_p}), 0);
    chk("midrst_rel", rel_cnt, 0);
    rst = 1'b0;
    clr_log();
    step(10);
    chk("midrst_repress_at", press_at, 6);
    chk("midrst_repress_cnt", press_cnt, 1);
    chk("midrst_no_rel", rel_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
